// File: rtl/mul_pipe_pkg.sv
// Shared operation encoding and sizing helpers for the pipelined multiplier.
package mul_pipe_pkg;

  typedef enum logic [1:0] {
    MUL    = 2'd0,
    MULXSS = 2'd1,
    MULXSU = 2'd2,
    MULXUU = 2'd3
  } mul_op_e;

  function automatic int calc_ns(input int data_w, input int slice_w);
    return data_w / slice_w;
  endfunction

  function automatic int calc_prod_w(input int data_w);
    return 2 * data_w;
  endfunction

  function automatic logic op_is_high(input mul_op_e op);
    return op != MUL;
  endfunction

  function automatic logic op_a_signed(input mul_op_e op);
    return (op == MULXSS) || (op == MULXSU);
  endfunction

endpackage

// File: rtl/mul_slice_cell.sv
// One registered unsigned SLICE_W x SLICE_W multiply; holds its product when en is low.
module mul_slice_cell #(
  parameter int SLICE_W = 16
) (
  input  logic                   clk,
  input  logic                   en,
  input  logic [SLICE_W-1:0]     a,
  input  logic [SLICE_W-1:0]     b,
  output logic [2*SLICE_W-1:0]   p
);

  logic [2*SLICE_W-1:0] p_reg;

  always_ff @(posedge clk) begin
    if (en) begin
      p_reg <= (2*SLICE_W)'(a) * (2*SLICE_W)'(b);
    end
  end

  assign p = p_reg;

endmodule

// File: rtl/mul_pipe_unit.sv
// Three-stage multiplier: partial products (S1), unsigned sum plus sign correction (S2),
// selected product word (S3), with valid/ready back-pressure and flush.
module mul_pipe_unit
  import mul_pipe_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SLICE_W = 16,
  parameter int TAG_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [TAG_W-1:0]  out_tag
);

  localparam int NS     = calc_ns(DATA_W, SLICE_W);
  localparam int PROD_W = calc_prod_w(DATA_W);

  if ((DATA_W % SLICE_W) != 0 || DATA_W < SLICE_W) begin : g_param_check
    $error("mul_pipe_unit: DATA_W (%0d) must be a nonzero multiple of SLICE_W (%0d)",
           DATA_W, SLICE_W);
  end

  logic              s1_valid_reg, s2_valid_reg, out_valid_reg;
  mul_op_e           s1_op_reg, s2_op_reg;
  logic [DATA_W-1:0] s1_a_reg, s1_b_reg;
  logic [TAG_W-1:0]  s1_tag_reg, s2_tag_reg, out_tag_reg;
  logic [PROD_W-1:0] s2_prod_reg, prod_sum_next;
  logic [DATA_W-1:0] s2_corr_reg, corr_next, high_word, result_next, out_result_reg;
  logic              in_fire, s1_adv, s2_adv, s3_can_load;

  logic [2*SLICE_W-1:0] pp [NS][NS];

  // Handshake chain: each stage moves when the one downstream is free or draining.
  assign s3_can_load = !out_valid_reg || out_ready;
  assign s2_adv      = s2_valid_reg && s3_can_load;
  assign s1_adv      = s1_valid_reg && (!s2_valid_reg || s2_adv);
  assign in_ready    = (!s1_valid_reg || s1_adv) && !flush;
  assign in_fire     = in_valid && in_ready;

  genvar gi, gj;
  for (gi = 0; gi < NS; gi++) begin : g_row
    for (gj = 0; gj < NS; gj++) begin : g_col
      mul_slice_cell #(.SLICE_W(SLICE_W)) u_cell (
        .clk (clk),
        .en  (in_fire),
        .a   (in_a[gi*SLICE_W +: SLICE_W]),
        .b   (in_b[gj*SLICE_W +: SLICE_W]),
        .p   (pp[gi][gj])
      );
    end
  end

  always_comb begin
    prod_sum_next = '0;
    for (int i = 0; i < NS; i++) begin
      for (int j = 0; j < NS; j++) begin
        prod_sum_next = prod_sum_next + (PROD_W'(pp[i][j]) << (SLICE_W * (i + j)));
      end
    end
  end

  // Signed operands read as unsigned overstate the high word by B (A<0) and A (B<0).
  always_comb begin
    corr_next = '0;
    if (op_a_signed(s1_op_reg) && s1_a_reg[DATA_W-1]) begin
      corr_next = corr_next + s1_b_reg;
    end
    if ((s1_op_reg == MULXSS) && s1_b_reg[DATA_W-1]) begin
      corr_next = corr_next + s1_a_reg;
    end
  end

  always_comb begin
    high_word   = s2_prod_reg[PROD_W-1 -: DATA_W] - s2_corr_reg;
    result_next = op_is_high(s2_op_reg) ? high_word : s2_prod_reg[DATA_W-1:0];
  end

  // Stage occupancy and the output register; reset wins over flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_reg   <= 1'b0;
      s2_valid_reg   <= 1'b0;
      out_valid_reg  <= 1'b0;
      out_result_reg <= '0;
      out_tag_reg    <= '0;
    end else if (flush) begin
      s1_valid_reg   <= 1'b0;
      s2_valid_reg   <= 1'b0;
      out_valid_reg  <= 1'b0;
    end else begin
      if (in_fire) begin
        s1_valid_reg <= 1'b1;
      end else if (s1_adv) begin
        s1_valid_reg <= 1'b0;
      end
      if (s1_adv) begin
        s2_valid_reg <= 1'b1;
      end else if (s2_adv) begin
        s2_valid_reg <= 1'b0;
      end
      if (s2_adv) begin
        out_valid_reg  <= 1'b1;
        out_result_reg <= result_next;
        out_tag_reg    <= s2_tag_reg;
      end else if (out_valid_reg && out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1_op_reg  <= mul_op_e'(in_op);
      s1_a_reg   <= in_a;
      s1_b_reg   <= in_b;
      s1_tag_reg <= in_tag;
    end
    if (s1_adv) begin
      s2_op_reg   <= s1_op_reg;
      s2_prod_reg <= prod_sum_next;
      s2_corr_reg <= corr_next;
      s2_tag_reg  <= s1_tag_reg;
    end
  end

  assign out_valid  = out_valid_reg;
  assign out_result = out_result_reg;
  assign out_tag    = out_tag_reg;

endmodule

// File: tb/tb_mul_pipe_unit.sv
// Bench for mul_pipe_unit: directed vectors and flow corners on a 32-bit instance,
// randomized scoreboard run on a 64-bit instance.
module tb_mul_pipe_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        f32, iv32, ir32, ov32, or32;
  logic [1:0]  op32;
  logic [31:0] a32, b32, res32;
  logic [4:0]  tg32, otg32;

  logic        f64, iv64, ir64, ov64, or64;
  logic [1:0]  op64;
  logic [63:0] a64, b64, res64;
  logic [4:0]  tg64, otg64;

  mul_pipe_unit #(.DATA_W(32), .SLICE_W(16), .TAG_W(5)) dut32 (
    .clk(clk), .reset(reset), .flush(f32), .in_valid(iv32), .in_ready(ir32),
    .in_op(op32), .in_a(a32), .in_b(b32), .in_tag(tg32),
    .out_valid(ov32), .out_ready(or32), .out_result(res32), .out_tag(otg32)
  );

  mul_pipe_unit #(.DATA_W(64), .SLICE_W(16), .TAG_W(5)) dut64 (
    .clk(clk), .reset(reset), .flush(f64), .in_valid(iv64), .in_ready(ir64),
    .in_op(op64), .in_a(a64), .in_b(b64), .in_tag(tg64),
    .out_valid(ov64), .out_ready(or64), .out_result(res64), .out_tag(otg64)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  tag;
  } exp_t;

  vec_t vecs[9];
  exp_t sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Full two's-complement product by sign extension to 128 bits, then word select.
  function automatic logic [63:0] ref64(input logic [1:0] op, input logic [63:0] a,
                                        input logic [63:0] b);
    logic [127:0] ea, eb, p;
    ea = (op == 2'd1 || op == 2'd2) ? {{64{a[63]}}, a} : {64'd0, a};
    eb = (op == 2'd1) ? {{64{b[63]}}, b} : {64'd0, b};
    p  = ea * eb;
    return (op == 2'd0) ? p[63:0] : p[127:64];
  endfunction

  function automatic logic [63:0] rnd_operand();
    logic [63:0] v;
    case ($urandom_range(0, 5))
      0: v = '1;
      1: v = 64'h8000_0000_0000_0000;
      2: v = 64'h7FFF_FFFF_FFFF_FFFF;
      3: v = '0;
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  task automatic issue32(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tag, input logic [31:0] exp);
    int lat;
    @(negedge clk);
    iv32 = 1'b1; op32 = op; a32 = a; b32 = b; tg32 = tag;
    #1 chk({name, " in_ready"}, 64'(ir32), 64'(1));
    @(negedge clk);
    iv32 = 1'b0;
    lat  = 1;
    while (!ov32 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk({name, " latency"}, 64'(lat), 64'(3));
    chk({name, " result"}, 64'(res32), 64'(exp));
    chk({name, " tag"}, 64'(otg32), 64'(tag));
    $display("txn %s op=%0d a=%h b=%h tag=%0d result=%h", name, op, a, b, tag, res32);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] held;
    int seen;

    vecs[0] = '{2'd3, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001};
    vecs[1] = '{2'd0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000};
    vecs[2] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[3] = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
    vecs[4] = '{2'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vecs[5] = '{2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[6] = '{2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[7] = '{2'd2, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF};
    vecs[8] = '{2'd1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000};

    reset = 1'b1;
    f32 = 0; iv32 = 0; or32 = 1; op32 = 0; a32 = 0; b32 = 0; tg32 = 0;
    f64 = 0; iv64 = 0; or64 = 1; op64 = 0; a64 = 0; b64 = 0; tg64 = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset out_valid", 64'(ov32), 64'(0));
    chk("reset in_ready", 64'(ir32), 64'(1));
    chk("reset out_result", 64'(res32), 64'(0));
    chk("reset out_tag", 64'(otg32), 64'(0));
    chk("reset64 out_valid", 64'(ov64), 64'(0));

    for (int i = 0; i < 9; i++) begin
      issue32($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1), vecs[i].exp);
    end

    // Back-pressure: three ops fill the pipe, the fourth waits.
    @(negedge clk);
    or32 = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      if (t > 1) @(negedge clk);
      iv32 = 1'b1; op32 = 2'd0; a32 = 32'(t); b32 = 32'd3; tg32 = 5'(t);
      #1 chk($sformatf("stall accept tag%0d", t), 64'(ir32), 64'(1));
    end
    @(negedge clk);
    a32 = 32'd4; tg32 = 5'd4;
    #1;
    chk("stall full in_ready", 64'(ir32), 64'(0));
    chk("stall head tag", 64'(otg32), 64'(1));
    chk("stall head result", 64'(res32), 64'(3));
    held = res32;
    repeat (2) @(negedge clk);
    #1;
    chk("stall hold result", 64'(res32), 64'(held));
    chk("stall hold tag", 64'(otg32), 64'(1));
    chk("stall still full", 64'(ir32), 64'(0));
    or32 = 1'b1;
    #1 chk("full accept+consume in_ready", 64'(ir32), 64'(1));
    for (int t = 1; t <= 4; t++) begin
      if (t > 1) begin
        @(negedge clk);
        iv32 = 1'b0;
        #1;
      end
      chk($sformatf("drain%0d valid", t), 64'(ov32), 64'(1));
      chk($sformatf("drain%0d tag", t), 64'(otg32), 64'(t));
      chk($sformatf("drain%0d result", t), 64'(res32), 64'(t * 3));
      $display("txn drain tag=%0d result=%h", otg32, res32);
    end
    @(negedge clk);
    #1 chk("drain empty", 64'(ov32), 64'(0));

    // Flush with two ops in flight and a third offered.
    @(negedge clk);
    iv32 = 1'b1; op32 = 2'd3; a32 = 32'hFFFF_FFFF; b32 = 32'h2; tg32 = 5'd5;
    @(negedge clk);
    tg32 = 5'd6;
    @(negedge clk);
    tg32 = 5'd7; f32 = 1'b1;
    #1 chk("flush in_ready", 64'(ir32), 64'(0));
    @(negedge clk);
    f32 = 1'b0; iv32 = 1'b0;
    seen = 0;
    repeat (5) begin
      #1;
      if (ov32) seen++;
      @(negedge clk);
    end
    chk("flush no output", 64'(seen), 64'(0));
    chk("flush keeps result", 64'(res32), 64'(12));
    $display("txn flush discarded tags 5-7");
    issue32("post-flush", 2'd2, 32'hFFFF_FFFE, 32'h0000_0003, 5'd8, 32'hFFFF_FFFF);

    // Randomized 64-bit run against the arithmetic reference.
    for (int i = 0; i < 640; i++) begin
      @(negedge clk);
      if (i == 350) begin
        reset = 1'b1; iv64 = 1'b0; f64 = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid reset out_valid", 64'(ov64), 64'(0));
        chk("mid reset out_result", res64, 64'(0));
        $display("txn reset mid-stream, %0d ops discarded", sb.size());
        sb.delete();
        continue;
      end
      if (i < 620) begin
        f64  = ($urandom_range(0, 39) == 0);
        or64 = f64 ? 1'b0 : ($urandom_range(0, 3) != 0);
        iv64 = ($urandom_range(0, 3) != 0);
        op64 = 2'($urandom_range(0, 3));
        a64  = rnd_operand();
        b64  = rnd_operand();
        tg64 = 5'($urandom_range(0, 31));
      end else begin
        f64 = 1'b0; or64 = 1'b1; iv64 = 1'b0;
      end
      #1;
      if (f64) begin
        chk("rnd flush in_ready", 64'(ir64), 64'(0));
        sb.delete();
      end else begin
        if (ov64 && or64) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rnd unexpected output: actual tag %0d result %0h required none", otg64, res64);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("rnd result", res64, e.res);
            chk("rnd tag", 64'(otg64), 64'(e.tag));
            $display("txn rnd tag=%0d result=%h", otg64, res64);
          end
        end
        if (iv64 && ir64) begin
          sb.push_back('{ref64(op64, a64, b64), tg64});
          chk("rnd in flight", 64'(sb.size() <= 3), 64'(1));
        end
      end
    end
    chk("rnd drained", 64'(sb.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
